stage_mem: RTL
==============

Name: stage_mem

Overview:
- Memory-access pipeline stage. Sits between the EX->MEM pipeline register (driven from the ALU result and operands) and the MEM->WB register.
- Non-memory instructions pass through in zero cycles.
- Loads and stores run a handshake with the data memory. The stage holds `stallreq_mem` to the control block until the access completes.
- Performs byte-lane steering for stores and alignment plus sign/zero extension for loads. Flags misaligned accesses.

Parameters:
- Width, 32, data and address width in bits. Only 32 is supported; the byte-lane logic assumes 4 lanes.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  EX->MEM register holds a live instruction
- in  in  rvcpu::stage_ex_mem_t  pc, res (ALU result/address), store_data, rd, rd_valid, mem_op
- stall  in  1  stall_mem from control; downstream will not take `out` this cycle
- dmem_req_valid  out  1  memory request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_addr  out  Width  word-aligned address, {res[31:2],2'b00}
- dmem_we  out  1  1 = store
- dmem_wstrb  out  4  byte enables
- dmem_wdata  out  Width  lane-steered store data
- dmem_rvalid  in  1  response / write acknowledge
- dmem_rdata  in  Width  read word
- stallreq_mem  out  1  stage busy; to control.stallreq_mem
- out_valid  out  1  `out` is valid
- out  out  rvcpu::stage_mem_t  pc, rd, rd_data, rd_valid
- misaligned  out  1  one-cycle misaligned-access flag

Behaviour:
- Reset (rst=0, asynchronous):
  - State becomes IDLE.
  - Captured load data clears to 0.
  - All outputs are 0 while reset is held.
  - Reset mid-access abandons the transaction. A late dmem_rvalid after reset release is ignored in IDLE.
- mem_op encoding: kind {NONE, LOAD, STORE}, size {B, H, W}, is_unsigned.
- Non-memory op (in_valid=1, kind=NONE), in IDLE:
  - Combinational pass-through: out_valid=1, rd_data=res, rd/rd_valid copied.
  - stallreq_mem=0.
- Misaligned access:
  - Condition: H with res[0]=1, or W with res[1:0]!=0.
  - No memory request is issued.
  - misaligned=1, out_valid=1, rd_valid forced 0.
  - stallreq_mem=0, state stays IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE, aligned LOAD/STORE:
    - dmem_req_valid=1 and stallreq_mem=1 combinationally.
    - Address, wstrb and wdata are latched at this edge.
    - dmem_req_ready=1 -> WAIT; otherwise -> REQ.
  - REQ:
    - dmem_req_valid=1 with the latched values, held stable until ready.
    - stallreq_mem=1.
    - dmem_req_ready=1 -> WAIT.
  - WAIT:
    - stallreq_mem=1, dmem_req_valid=0.
    - dmem_rvalid=1 -> capture dmem_rdata, go to DONE.
  - DONE:
    - out_valid=1, stallreq_mem=0.
    - Loads: rd_data is the extracted value. Stores: rd_valid=0.
    - stall=0 -> IDLE. stall=1 -> hold DONE with outputs stable.
- The stage never has more than one outstanding request.
- Minimum load latency is 2 cycles after request acceptance (WAIT then DONE).
- Store steering:
  - B: wstrb=4'b0001<<res[1:0], wdata={4{sd[7:0]}}.
  - H: wstrb=4'b0011<<{res[1],1'b0}, wdata={2{sd[15:0]}}.
  - W: wstrb=4'b1111, wdata=sd.
- Load extraction: shift the captured word right by 8*res[1:0], then:
  - B: sign- or zero-extend from bit 7.
  - H: sign- or zero-extend from bit 15.
  - W: unchanged.
- in_valid=0 in IDLE: out_valid=0 and no request.
- Inputs are sampled only in IDLE. Control holds the EX->MEM register stable while stallreq_mem=1.

Decomposition:
- rvcpu package additions:
  - mem_kind_t, mem_size_t, mem_op_t (packed {kind, size, is_unsigned}).
  - stage_ex_mem_t.
  - stage_mem_t.
  - memstate_t enum.
- stage_ex_t grows into stage_ex_mem_t; top wiring is updated accordingly.
- Natural sub-module: `lsu_align`, combinational. It computes wstrb/wdata from size/addr/store_data and load extraction from size/is_unsigned/addr/rdata, plus the misaligned check.

Test Plan:
- ADD pass-through, res=0x0000_1234, rd=5 -> same cycle out_valid=1, rd_data=0x1234, stallreq_mem=0, no dmem_req_valid.
- LB at 0x103, memory returns 0x80FF_0000 with ready same cycle and rvalid next cycle -> dmem_addr=0x100; after DONE rd_data=0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- SH at 0x202, store_data=0xAAAA_BEEF, ready held low 3 cycles -> dmem_req_valid held 4 cycles with wstrb=4'b1100, wdata=0xBEEF_BEEF; stallreq_mem=1 until DONE; rd_valid=0.
- LW at 0x006 -> misaligned=1 for one cycle, no dmem_req_valid, out rd_valid=0.
- LW completes while stall=1 for 2 cycles -> out_valid and rd_data stable in DONE for 3 cycles, then IDLE.
- rst=0 asserted while in WAIT; rvalid pulses after release -> state IDLE, out_valid=0, response ignored.

Source files
------------

// File: rtl/rvcpu_pkg.sv
// rvcpu_pkg: shared types for the memory-access pipeline stage.
//   mem_kind_t / mem_size_t / mem_op_t : memory operation encoding
//   stage_ex_mem_t : EX->MEM pipeline register contents
//   stage_mem_t    : MEM->WB pipeline register contents
//   memstate_t     : stage_mem access FSM states
package rvcpu;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_kind_t;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_t;

    typedef struct packed {
        mem_kind_t kind;
        mem_size_t size;
        logic      is_unsigned;
    } mem_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;         // ALU result; the effective address for loads/stores
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        rd_valid;
        mem_op_t     mem_op;
    } stage_ex_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        rd_valid;
    } stage_mem_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } memstate_t;

    function automatic logic is_mem(input mem_op_t op);
        return (op.kind == MEM_LOAD) || (op.kind == MEM_STORE);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the memory stage.
//   op         : memory operation (kind, size, is_unsigned)
//   addr_lo    : low two address bits (byte offset within the word)
//   store_data : register value to be stored
//   rdata      : word read from memory
//   wstrb      : byte enables for a store
//   wdata      : store data replicated onto every lane it may occupy
//   load_data  : load result, aligned down and sign/zero extended
//   misaligned : halfword on an odd address or word not on a 4-byte boundary
module lsu_align
    import rvcpu::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        wstrb     = '0;
        wdata     = '0;
        load_data = '0;
        shifted   = rdata >> {addr_lo, 3'b000};

        case (op.size)
            SIZE_B: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = op.is_unsigned ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata     = {2{store_data[15:0]}};
                load_data = op.is_unsigned ? {16'h0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            end
            SIZE_W: begin
                wstrb     = 4'b1111;
                wdata     = store_data;
                load_data = shifted;
            end
            default: ;
        endcase

        misaligned = is_mem(op) &&
                     (((op.size == SIZE_H) && addr_lo[0]) ||
                      ((op.size == SIZE_W) && (addr_lo != 2'b00)));
    end

endmodule

// File: rtl/stage_mem.sv
// stage_mem: memory-access pipeline stage between EX->MEM and MEM->WB.
//   clk, rst                : clock (rising edge), async active-low reset
//   in_valid, in            : live instruction from the EX->MEM register
//   stall                   : downstream will not take `out` this cycle
//   dmem_req_valid/ready    : request handshake to data memory
//   dmem_addr/we/wstrb/wdata: word address, write flag, byte enables, data
//   dmem_rvalid, dmem_rdata : read response / write acknowledge
//   stallreq_mem            : stage busy with an access
//   out_valid, out          : result towards MEM->WB
//   misaligned              : misaligned access flag
// Non-memory ops pass straight through; loads/stores run one request at a
// time through IDLE -> (REQ) -> WAIT -> DONE.
module stage_mem
    import rvcpu::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  stage_ex_mem_t    in,
    input  logic             stall,
    output logic             dmem_req_valid,
    input  logic             dmem_req_ready,
    output logic [Width-1:0] dmem_addr,
    output logic             dmem_we,
    output logic [3:0]       dmem_wstrb,
    output logic [Width-1:0] dmem_wdata,
    input  logic             dmem_rvalid,
    input  logic [Width-1:0] dmem_rdata,
    output logic             stallreq_mem,
    output logic             out_valid,
    output stage_mem_t       out,
    output logic             misaligned
);

    memstate_t        state;
    stage_ex_mem_t    req_q;     // operation captured when the access starts
    logic [Width-1:0] rdata_q;

    stage_ex_mem_t cur;
    logic [3:0]    lsu_wstrb;
    logic [31:0]   lsu_wdata;
    logic [31:0]   lsu_load;
    logic          lsu_mis;
    logic          start;

    // In IDLE the live input drives the lane logic; afterwards the captured
    // copy does, so request fields stay stable and the load result can be
    // extracted in DONE even after the EX->MEM register has moved on.
    assign cur = (state == ST_IDLE) ? in : req_q;

    lsu_align u_lsu_align (
        .op         (cur.mem_op),
        .addr_lo    (cur.res[1:0]),
        .store_data (cur.store_data),
        .rdata      (rdata_q),
        .wstrb      (lsu_wstrb),
        .wdata      (lsu_wdata),
        .load_data  (lsu_load),
        .misaligned (lsu_mis)
    );

    assign start = (state == ST_IDLE) && in_valid && is_mem(in.mem_op) && !lsu_mis;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    req_q <= in;
                    state <= dmem_req_ready ? ST_WAIT : ST_REQ;
                end
                ST_REQ:  if (dmem_req_ready) state <= ST_WAIT;
                ST_WAIT: if (dmem_rvalid) begin
                    rdata_q <= dmem_rdata;
                    state   <= ST_DONE;
                end
                ST_DONE: if (!stall) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dmem_req_valid = 1'b0;
        dmem_addr      = '0;
        dmem_we        = 1'b0;
        dmem_wstrb     = '0;
        dmem_wdata     = '0;
        stallreq_mem   = 1'b0;
        out_valid      = 1'b0;
        out            = '0;
        misaligned     = 1'b0;

        // Outputs are forced low while reset is held, including the
        // combinational IDLE paths that would otherwise follow `in`.
        if (rst) begin
            if (start || (state == ST_REQ)) begin
                dmem_req_valid = 1'b1;
                stallreq_mem   = 1'b1;
                dmem_addr      = {cur.res[31:2], 2'b00};
                dmem_we        = (cur.mem_op.kind == MEM_STORE);
                dmem_wstrb     = dmem_we ? lsu_wstrb : 4'b0000;
                dmem_wdata     = dmem_we ? lsu_wdata : '0;
            end

            case (state)
                ST_IDLE: if (in_valid && !start) begin
                    // Non-memory op or misaligned access: answered this cycle.
                    out_valid    = 1'b1;
                    out.pc       = in.pc;
                    out.rd       = in.rd;
                    misaligned   = lsu_mis;
                    if (!lsu_mis) begin
                        out.rd_data  = in.res;
                        out.rd_valid = in.rd_valid;
                    end
                end
                ST_WAIT: stallreq_mem = 1'b1;
                ST_DONE: begin
                    out_valid = 1'b1;
                    out.pc    = req_q.pc;
                    out.rd    = req_q.rd;
                    if (req_q.mem_op.kind == MEM_LOAD) begin
                        out.rd_data  = lsu_load;
                        out.rd_valid = req_q.rd_valid;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
